// File: rtl/sblk_ctrl.sv
// SuperBlock sequencer: streams activations into the tile buffers, sweeps
// weight/activation/psum read addresses, and replays each issue as a psum
// write-back PSUM_LAT clk_l cycles later.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; config latched on start
// S_LOAD    | accepting activation beats, tile-major into the tile buffers
// S_COMPUTE | one read issue per cycle, padded with bubbles on short passes
// S_DRAIN   | no more issues; waiting for outstanding write-backs
// S_DONE    | one-cycle done pulse
module sblk_ctrl #(
    parameter int N_TILE       = 40,
    parameter int WID_ACT      = 16,
    parameter int WID_ACTADDR  = 6,
    parameter int WID_WADDR    = 10,
    parameter int WID_PSUMADDR = 9,
    parameter int PSUM_LAT     = 24
) (
    input  logic                    clk_l,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WID_ACTADDR-2:0]  cfg_n_act_m1,
    input  logic [WID_PSUMADDR-1:0] cfg_n_out_m1,
    output logic                    busy,
    output logic                    done,
    input  logic [2*WID_ACT-1:0]    act_in_data,
    input  logic                    act_in_valid,
    output logic                    act_in_ready,
    output logic [2*WID_ACT-1:0]    act_data_out,
    output logic [N_TILE-1:0]       act_wr_en,
    output logic [WID_ACTADDR-2:0]  act_wr_addr_hbit,
    output logic [WID_ACTADDR-2:0]  act_rd_addr_hbit,
    output logic [WID_WADDR-1:0]    w_rd_addr,
    output logic [WID_PSUMADDR-1:0] psum_rd_addr,
    output logic [WID_PSUMADDR-1:0] psum_wr_addr,
    output logic                    psum_wr_en
);

    localparam int TW = (N_TILE > 1) ? $clog2(N_TILE) : 1;
    // Bubble counter holds at most PSUM_LAT-2.
    localparam int BW = (PSUM_LAT > 1) ? $clog2(PSUM_LAT) : 1;
    localparam int LW = $clog2(PSUM_LAT + 1);
    localparam int RW = ((WID_PSUMADDR > LW) ? WID_PSUMADDR : LW) + 1;
    localparam logic [PSUM_LAT-1:0] TOP_BIT = PSUM_LAT'(1) << (PSUM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WID_ACTADDR-2:0]  na_q;
    logic [WID_PSUMADDR-1:0] no_q;
    logic [TW-1:0]           ld_tile_q;
    logic [WID_ACTADDR-2:0]  ld_word_q;
    logic [WID_ACTADDR-2:0]  a_q;
    logic [WID_PSUMADDR-1:0] r_q;
    logic [WID_WADDR-1:0]    w_q;
    logic                    issue_q;
    logic [BW-1:0]           bub_q;
    logic [PSUM_LAT-1:0]     sr_vld;
    logic [WID_PSUMADDR-1:0] sr_row [PSUM_LAT];

    logic                    ld_accept;
    logic                    ld_word_last;
    logic                    ld_tile_last;
    logic                    pass_end;
    logic                    sr_pending;
    logic [RW-1:0]           rows;
    logic                    need_pad;
    logic [BW-1:0]           pad_m1;

    // Gated so that every output reads 0 while reset is held.
    assign act_data_out     = rst_n ? act_in_data : '0;
    assign act_rd_addr_hbit = a_q;
    assign psum_rd_addr     = r_q;
    assign w_rd_addr        = w_q;
    assign psum_wr_en       = sr_vld[PSUM_LAT-1];
    assign psum_wr_addr     = sr_row[PSUM_LAT-1];

    // A pass shorter than the write-back latency is stretched with bubbles
    // so a row is never re-read before its write-back lands.
    assign rows     = RW'(no_q) + RW'(1);
    assign need_pad = rows < RW'(PSUM_LAT);
    assign pad_m1   = BW'(RW'(PSUM_LAT) - rows - RW'(1));

    // Loop-position decode shared by the FSM and the counters.
    always_comb begin
        ld_accept    = (state_q == S_LOAD) && act_in_valid;
        ld_word_last = (ld_word_q == na_q);
        ld_tile_last = (ld_tile_q == TW'(N_TILE - 1));
        pass_end     = (issue_q && (r_q == no_q) && !need_pad) ||
                       (!issue_q && (bub_q == '0));
        // The top stage is the write-back leaving this cycle.
        sr_pending   = |(sr_vld & ~TOP_BIT);
    end

    // State register.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d      = state_q;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        act_in_ready = 1'b0;
        case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD;
            S_LOAD: begin
                act_in_ready = 1'b1;
                if (ld_accept && ld_word_last && ld_tile_last) state_d = S_COMPUTE;
            end
            S_COMPUTE: if (pass_end && (a_q == na_q)) state_d = S_DRAIN;
            S_DRAIN:   if (!sr_pending) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Config latch, load counters, and read-address sweep.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            na_q             <= '0;
            no_q             <= '0;
            ld_tile_q        <= '0;
            ld_word_q        <= '0;
            act_wr_en        <= '0;
            act_wr_addr_hbit <= '0;
            a_q              <= '0;
            r_q              <= '0;
            w_q              <= '0;
            issue_q          <= 1'b0;
            bub_q            <= '0;
        end else begin
            act_wr_en <= '0;
            case (state_q)
                S_IDLE: if (start) begin
                    na_q      <= cfg_n_act_m1;
                    no_q      <= cfg_n_out_m1;
                    ld_tile_q <= '0;
                    ld_word_q <= '0;
                    a_q       <= '0;
                    r_q       <= '0;
                    w_q       <= '0;
                    bub_q     <= '0;
                end
                S_LOAD: if (ld_accept) begin
                    act_wr_en        <= N_TILE'(1) << ld_tile_q;
                    act_wr_addr_hbit <= ld_word_q;
                    if (ld_word_last) begin
                        ld_word_q <= '0;
                        ld_tile_q <= ld_tile_q + TW'(1);
                        if (ld_tile_last) begin
                            issue_q <= 1'b1;
                            a_q     <= '0;
                            r_q     <= '0;
                            w_q     <= '0;
                        end
                    end else begin
                        ld_word_q <= ld_word_q + (WID_ACTADDR-1)'(1);
                    end
                end
                S_COMPUTE: begin
                    if (issue_q && (r_q != no_q)) begin
                        r_q <= r_q + WID_PSUMADDR'(1);
                        w_q <= w_q + WID_WADDR'(1);
                    end else if (issue_q && need_pad) begin
                        issue_q <= 1'b0;
                        bub_q   <= pad_m1;
                    end else if (!issue_q && (bub_q != '0)) begin
                        bub_q <= bub_q - BW'(1);
                    end else if (a_q != na_q) begin
                        a_q     <= a_q + (WID_ACTADDR-1)'(1);
                        r_q     <= '0;
                        w_q     <= w_q + WID_WADDR'(1);
                        issue_q <= 1'b1;
                    end else begin
                        issue_q <= 1'b0;
                    end
                end
                default: issue_q <= 1'b0;
            endcase
        end
    end

    // Write-back delay line: issue valid and row, PSUM_LAT stages deep.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            sr_vld <= '0;
            for (int i = 0; i < PSUM_LAT; i++) sr_row[i] <= '0;
        end else begin
            sr_vld <= (sr_vld << 1) | PSUM_LAT'(issue_q);
            for (int i = PSUM_LAT - 1; i > 0; i--) sr_row[i] <= sr_row[i-1];
            sr_row[0] <= issue_q ? r_q : '0;
        end
    end

endmodule

// File: tb/tb_sblk_ctrl.sv
// Bench for sblk_ctrl: randomized runs against a queue-based reference of
// the expected beat order and issue schedule; a negedge monitor pops and
// checks every tile write, psum write-back and done pulse.
module tb_sblk_ctrl;

    localparam int N_TILE       = 4;
    localparam int WID_ACT      = 16;
    localparam int WID_ACTADDR  = 6;
    localparam int WID_WADDR    = 10;
    localparam int WID_PSUMADDR = 9;
    localparam int PSUM_LAT     = 4;

    logic                    clk_l = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [WID_ACTADDR-2:0]  cfg_n_act_m1 = '0;
    logic [WID_PSUMADDR-1:0] cfg_n_out_m1 = '0;
    logic [2*WID_ACT-1:0]    act_in_data = '0;
    logic                    act_in_valid = 1'b0;

    logic                    busy, done, act_in_ready, psum_wr_en;
    logic [2*WID_ACT-1:0]    act_data_out;
    logic [N_TILE-1:0]       act_wr_en;
    logic [WID_ACTADDR-2:0]  act_wr_addr_hbit, act_rd_addr_hbit;
    logic [WID_WADDR-1:0]    w_rd_addr;
    logic [WID_PSUMADDR-1:0] psum_rd_addr, psum_wr_addr;

    logic                    w3_busy, w3_done, w3_act_in_ready, w3_psum_wr_en;
    logic [2*WID_ACT-1:0]    w3_act_data_out;
    logic [N_TILE-1:0]       w3_act_wr_en;
    logic [WID_ACTADDR-2:0]  w3_act_wr_addr_hbit, w3_act_rd_addr_hbit;
    logic [2:0]              w3_w_rd_addr;
    logic [WID_PSUMADDR-1:0] w3_psum_rd_addr, w3_psum_wr_addr;

    sblk_ctrl #(.N_TILE(N_TILE), .WID_ACT(WID_ACT), .WID_ACTADDR(WID_ACTADDR),
                .WID_WADDR(WID_WADDR), .WID_PSUMADDR(WID_PSUMADDR), .PSUM_LAT(PSUM_LAT)) u_dut (
        .clk_l(clk_l), .rst_n(rst_n), .start(start),
        .cfg_n_act_m1(cfg_n_act_m1), .cfg_n_out_m1(cfg_n_out_m1),
        .busy(busy), .done(done),
        .act_in_data(act_in_data), .act_in_valid(act_in_valid), .act_in_ready(act_in_ready),
        .act_data_out(act_data_out), .act_wr_en(act_wr_en),
        .act_wr_addr_hbit(act_wr_addr_hbit), .act_rd_addr_hbit(act_rd_addr_hbit),
        .w_rd_addr(w_rd_addr), .psum_rd_addr(psum_rd_addr),
        .psum_wr_addr(psum_wr_addr), .psum_wr_en(psum_wr_en)
    );

    // Same stimulus, 3-bit weight address, to see the weight counter wrap.
    sblk_ctrl #(.N_TILE(N_TILE), .WID_ACT(WID_ACT), .WID_ACTADDR(WID_ACTADDR),
                .WID_WADDR(3), .WID_PSUMADDR(WID_PSUMADDR), .PSUM_LAT(PSUM_LAT)) u_dut_w3 (
        .clk_l(clk_l), .rst_n(rst_n), .start(start),
        .cfg_n_act_m1(cfg_n_act_m1), .cfg_n_out_m1(cfg_n_out_m1),
        .busy(w3_busy), .done(w3_done),
        .act_in_data(act_in_data), .act_in_valid(act_in_valid), .act_in_ready(w3_act_in_ready),
        .act_data_out(w3_act_data_out), .act_wr_en(w3_act_wr_en),
        .act_wr_addr_hbit(w3_act_wr_addr_hbit), .act_rd_addr_hbit(w3_act_rd_addr_hbit),
        .w_rd_addr(w3_w_rd_addr), .psum_rd_addr(w3_psum_rd_addr),
        .psum_wr_addr(w3_psum_wr_addr), .psum_wr_en(w3_psum_wr_en)
    );

    always #5 clk_l = ~clk_l;

    typedef struct { int tile; int word; } beat_t;
    typedef struct { int a; int r; int w; int off; } iss_t;

    beat_t exp_beat[$];
    iss_t  exp_iss[$];
    int    last_rd[int];
    int    hist_a[64], hist_r[64], hist_w[64], hist_w3[64];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int first_cyc = -1, last_psum_cyc = -1;
    int done_cnt = 0, psum_cnt = 0;

    logic [45:0] ctl_pack;
    assign ctl_pack = {busy, done, act_in_ready, act_wr_en, act_wr_addr_hbit, act_rd_addr_hbit,
                       w_rd_addr, psum_rd_addr, psum_wr_addr, psum_wr_en};

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk_l) cyc <= cyc + 1;

    // Monitor: sample away from the active edge and score against the queues.
    always @(negedge clk_l) begin : mon
        beat_t b;
        iss_t  s;
        int    ic;
        if (rst_n) begin
            hist_a[cyc % 64]  = int'(act_rd_addr_hbit);
            hist_r[cyc % 64]  = int'(psum_rd_addr);
            hist_w[cyc % 64]  = int'(w_rd_addr);
            hist_w3[cyc % 64] = int'(w3_w_rd_addr);
            if (act_wr_en != '0) begin
                if (exp_beat.size() == 0) begin
                    chk("unexpected act_wr_en", longint'(act_wr_en), 0);
                end else begin
                    b = exp_beat.pop_front();
                    chk("act_wr_en onehot", longint'(act_wr_en), longint'(1) << b.tile);
                    chk("act_wr_addr_hbit", longint'(act_wr_addr_hbit), b.word);
                    if (exp_beat.size() == 0) first_cyc = cyc;
                end
            end
            if (psum_wr_en) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected psum_wr_en", 1, 0);
                end else begin
                    s  = exp_iss.pop_front();
                    ic = cyc - PSUM_LAT;
                    chk("issue cycle", ic, first_cyc + s.off);
                    if (ic < 0) ic = 0;
                    chk("psum_wr_addr", longint'(psum_wr_addr), s.r);
                    chk("psum_rd_addr at issue", hist_r[ic % 64], s.r);
                    chk("act_rd_addr at issue", hist_a[ic % 64], s.a);
                    chk("w_rd_addr at issue", hist_w[ic % 64], s.w % (1 << WID_WADDR));
                    chk("w_rd_addr 3b at issue", hist_w3[ic % 64], s.w % 8);
                    if (last_rd.exists(s.r))
                        chk("row reread gap >= latency", longint'((ic - last_rd[s.r]) >= PSUM_LAT), 1);
                    last_rd[s.r]  = ic;
                    last_psum_cyc = cyc;
                    psum_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done one cycle after last write", cyc, last_psum_cyc + 1);
                chk("write-backs left at done", exp_iss.size(), 0);
            end
        end
    end

    // mode: 0 back-to-back, 1 fixed 1,0,0,1,1,0,1 toggle, 2 random valid.
    task automatic run_case(input int na, input int no, input int mode,
                            input bit start_busy, input bit mid_reset);
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int p, k, nb, acc, guard, total;
        exp_beat.delete();
        exp_iss.delete();
        last_rd.delete();
        for (int t = 0; t < N_TILE; t++)
            for (int w = 0; w <= na; w++) exp_beat.push_back('{t, w});
        p = (no + 1 < PSUM_LAT) ? PSUM_LAT : no + 1;
        k = 0;
        for (int a = 0; a <= na; a++)
            for (int r = 0; r <= no; r++) begin
                exp_iss.push_back('{a, r, k, a * p + r});
                k++;
            end
        total = k;
        first_cyc = -1; last_psum_cyc = -1; done_cnt = 0; psum_cnt = 0;

        @(negedge clk_l); #1;
        act_in_valid = 1'b0;
        cfg_n_act_m1 = (WID_ACTADDR-1)'(na);
        cfg_n_out_m1 = WID_PSUMADDR'(no);
        start = 1'b1;
        @(negedge clk_l); #1;
        start = 1'b0;
        cfg_n_act_m1 = (WID_ACTADDR-1)'($urandom);
        cfg_n_out_m1 = WID_PSUMADDR'($urandom);
        chk("busy after start", longint'(busy), 1);
        chk("act_in_ready after start", longint'(act_in_ready), 1);

        nb = N_TILE * (na + 1); acc = 0; k = 0; guard = 0;
        while (acc < nb && guard < 1000) begin
            case (mode)
                0:       act_in_valid = 1'b1;
                1:       act_in_valid = pat[k % 7] != 0;
                default: act_in_valid = $urandom_range(0, 3) != 0;
            endcase
            act_in_data = $urandom;
            start = start_busy && (acc == 1);
            if (start) begin
                cfg_n_act_m1 = (WID_ACTADDR-1)'($urandom);
                cfg_n_out_m1 = WID_PSUMADDR'($urandom);
            end
            k++;
            #1;
            chk("act_data_out pass-through", longint'(act_data_out), longint'(act_in_data));
            if (act_in_valid && act_in_ready) acc++;
            @(negedge clk_l); #1;
            guard++;
        end
        chk("beats accepted", acc, nb);
        start = 1'b0;
        act_in_valid = 1'b1;
        chk("act_in_ready after load", longint'(act_in_ready), 0);

        if (mid_reset) begin
            @(negedge clk_l); #1;
            @(negedge clk_l); #1;
            rst_n = 1'b0;
            #1;
            chk("outputs under reset", longint'(ctl_pack), 0);
            chk("act_data_out under reset", longint'(act_data_out), 0);
            exp_beat.delete();
            exp_iss.delete();
            last_rd.delete();
            @(negedge clk_l); #1;
            rst_n = 1'b1;
            repeat (3 * PSUM_LAT + 4) @(negedge clk_l);
            #1;
            chk("no done after reset", done_cnt, 0);
            chk("idle after reset", longint'(busy), 0);
            act_in_valid = 1'b0;
            return;
        end

        if (start_busy) begin
            guard = 0;
            while (psum_cnt < total - 1 && guard < 2000) begin
                @(negedge clk_l); #1;
                guard++;
            end
            chk("busy while draining", longint'(busy), 1);
            start = 1'b1;
            cfg_n_act_m1 = (WID_ACTADDR-1)'($urandom);
            cfg_n_out_m1 = WID_PSUMADDR'($urandom);
            @(negedge clk_l); #1;
            start = 1'b0;
        end

        guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            @(negedge clk_l); #1;
            guard++;
        end
        chk("done seen", done_cnt, 1);
        repeat (4) @(negedge clk_l);
        #1;
        chk("single done pulse", done_cnt, 1);
        chk("idle after done", longint'(busy), 0);
        chk("psum write count", psum_cnt, total);
        chk("beats left", exp_beat.size(), 0);
        act_in_valid = 1'b0;
    endtask

    initial begin
        act_in_data = $urandom;
        act_in_valid = 1'b1;
        #12;
        chk("outputs at reset", longint'(ctl_pack), 0);
        chk("act_data_out at reset", longint'(act_data_out), 0);
        act_in_valid = 1'b0;
        @(negedge clk_l);
        rst_n = 1'b1;
        #1;
        chk("outputs after release", longint'(ctl_pack), 0);

        run_case(1, 5, 0, 1'b0, 1'b0);   // basic, also weight wrap on the 3-bit copy
        run_case(2, 1, 0, 1'b0, 1'b0);   // hazard padding
        run_case(0, 2, 1, 1'b0, 1'b0);   // back-pressure toggle
        run_case(0, 0, 0, 1'b0, 1'b0);   // single-row passes, maximum padding
        run_case(1, 5, 2, 1'b1, 1'b0);   // start while busy
        run_case(1, 5, 0, 1'b0, 1'b1);   // reset mid-compute
        run_case(1, 5, 0, 1'b0, 1'b0);   // clean rerun after reset
        for (int i = 0; i < 6; i++)
            run_case(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sblk_ctrl.md
# sblk_ctrl

Sequencer for one SuperBlock unit. On a start pulse it loads activation words into the per-tile activation buffers from a valid/ready stream. It then sweeps weight, activation and psum addresses through the tile chain, and issues psum write-backs delayed by the datapath latency. It runs entirely in the `clk_l` domain and drives the address/enable inputs of the SuperBlock unit; the `clk_h` half-select is generated inside the unit.

## Interface
- `N_TILE`, 40, number of tiles in the chain; sets the `act_wr_en` width.
- `WID_ACT`, 16, activation width; the stream carries 2 words per beat.
- `WID_ACTADDR`, 6, activation buffer address width; the controller drives the upper `WID_ACTADDR-1` bits.
- `WID_WADDR`, 10, weight buffer address width.
- `WID_PSUMADDR`, 9, psum buffer address width.
- `PSUM_LAT`, 24, `clk_l` cycles from a psum read issue to its matching write-back (≥1).
- `clk_l  in  1`: sole clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: run request; sampled only in IDLE.
- `cfg_n_act_m1  in  WID_ACTADDR-1`: activation words per tile minus 1.
- `cfg_n_out_m1  in  WID_PSUMADDR`: psum rows minus 1.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse at end of run.
- `act_in_data  in  2*WID_ACT`: activation beat.
- `act_in_valid  in  1`: activation beat valid.
- `act_in_ready  out  1`: controller can accept a beat.
- `act_data_out  out  2*WID_ACT`: combinational pass-through of `act_in_data`.
- `act_wr_en  out  N_TILE`: one-hot tile write enable.
- `act_wr_addr_hbit  out  WID_ACTADDR-1`: activation write word address.
- `act_rd_addr_hbit  out  WID_ACTADDR-1`: activation read word address.
- `w_rd_addr  out  WID_WADDR`: weight read address.
- `psum_rd_addr  out  WID_PSUMADDR`: psum read address.
- `psum_wr_addr  out  WID_PSUMADDR`: psum write address.
- `psum_wr_en  out  1`: psum write enable.

## Operation
- States: IDLE → LOAD → COMPUTE → DRAIN → DONE → IDLE.
- **IDLE**
  - `start`=1 latches `cfg_n_act_m1` (NA) and `cfg_n_out_m1` (NO), clears counters, then goes to LOAD.
  - `start` in any other state is ignored.
  - Config inputs are don't-care after latching.
- **LOAD**
  - `act_in_ready`=1.
  - Each accepted beat (valid&ready) writes tile t, word w.
  - Order is tile-major: w runs 0..NA, then t increments 0..N_TILE-1.
  - After beat (t=N_TILE-1, w=NA) is accepted: `act_in_ready` drops and the next state is COMPUTE.
- **COMPUTE**
  - Outer loop a=0..NA; inner loop r=0..NO.
  - One issue per cycle: `act_rd_addr_hbit`=a, `psum_rd_addr`=r, `w_rd_addr`=weight counter.
  - The weight counter starts at 0, increments per issue and wraps modulo 2^`WID_WADDR`.
- **Hazard rule**
  - If NO+1 < `PSUM_LAT`, each inner pass is padded with `PSUM_LAT`-(NO+1) bubble cycles after r=NO.
  - During bubbles, addresses hold and no issue occurs.
  - This guarantees a row is never re-read before its write-back.
- **Issue pipeline**: an issue-valid/row shift register of depth `PSUM_LAT` produces `psum_wr_en`/`psum_wr_addr`.
- **DRAIN**: entered after the last issue (a=NA, r=NO, plus any trailing bubbles). Wait until the shift register is empty.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **Reset (at any time, including mid-run)**
  - All outputs go to 0 and the shift register is cleared.
  - The next state is IDLE; no partial psum writes occur after reset release.

## Timing
- Reset values are 0 for every output, including `act_in_ready` and `busy`.
- Sequence:
  - `start` sampled at edge 0.
  - `busy`=1 and `act_in_ready`=1 from cycle 1.
  - A beat is accepted at cycle k.
  - At k+1, `act_wr_en`/`act_wr_addr_hbit` are registered. This aligns with the unit's internal one-cycle `act_data` register.
- First COMPUTE issue occurs the cycle after the last LOAD beat is accepted.
- `psum_wr_en`/`psum_wr_addr` equal the issue valid/row exactly `PSUM_LAT` cycles later.
- `done` is asserted the cycle after the last `psum_wr_en`.
- `act_in_valid` outside LOAD is ignored; back-pressure stalls with no lost beats.
- `act_rd_addr_hbit` and `psum_rd_addr` are registered outputs.

## Test plan
All scenarios use N_TILE=4, PSUM_LAT=4.
- **Basic MV**: NA=1, NO=5, 8 beats streamed back-to-back.
  - `act_wr_en` sequence 1,1,2,2,4,4,8,8 with addr 0,1,0,1,…
  - 12 issues with `w_rd_addr` 0..11, `act_rd_addr_hbit` 0×6 then 1×6.
  - 12 `psum_wr_en` with rows 0..5,0..5, each 4 cycles after its issue.
  - One `done` pulse.
- **Hazard padding**: NA=2, NO=1.
  - Each pass is 4 cycles: r=0, r=1, then 2 bubbles.
  - 6 issues, `w_rd_addr` 0..5.
  - No psum write to row r occurs within 4 cycles of a read of row r.
- **Back-pressure**: NA=0, `act_in_valid` toggling 1,0,0,1,1,0,1.
  - Exactly 4 writes, to tiles 1,2,4,8 one-hot.
  - COMPUTE starts the cycle after the 4th accepted beat.
- **Start while busy**: pulse `start` during LOAD and again during DRAIN.
  - No restart; a single `done` pulse.
  - Latched config is unchanged.
- **Reset mid-COMPUTE**: assert `rst_n`=0 after 3 issues.
  - All outputs are 0 asynchronously.
  - No `psum_wr_en` after release; a new `start` runs cleanly from tile 0.
- **Weight wrap**: `WID_WADDR`=3, NA=1, NO=5: `w_rd_addr` sequence 0..7,0..3.
